fp_pack_normalize: RTL

//  Final stage of the FP32 adder datapath; inverse of the operand field splitter.

---
 rtl/fp_pack_normalize_pkg.sv | 20 ++
 rtl/fp_pack_normalize_if.sv | 25 ++
 rtl/fp_round_rne.sv | 18 +
 rtl/fp_pack_normalize.sv | 106 ++++++++++
 4 files changed

// File: rtl/fp_pack_normalize_pkg.sv
// Shared types and constants for the FP32 pack/normalize stage.
package fp_pack_normalize_pkg;

  localparam int unsigned BIAS    = 127;
  localparam logic [7:0]  EXP_INF = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp_pack_normalize_if.sv
// Operand-in / packed-result-out handshake bundle for fp_pack_normalize.
interface fp_pack_normalize_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned GRS_W  = 3
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         in_sign;
  logic [EXP_W:0]               in_exp;
  logic [FRAC_W+GRS_W+1:0]      in_mant;
  logic                         out_valid;
  logic                         out_ready;
  logic [EXP_W+FRAC_W:0]        out_data;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on {exponent field, fraction} using guard/round/sticky.
module fp_round_rne #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23
) (
  input  logic [EXP_W-1:0]        exp_field,
  input  logic [FRAC_W-1:0]       frac,
  input  logic                    guard,
  input  logic                    round_bit,
  input  logic                    sticky,
  output logic [EXP_W+FRAC_W-1:0] result
);
  logic inc;

  assign inc = guard & (round_bit | sticky | frac[0]);
  // Fraction carry ripples into the exponent field: denormal->normal, max->infinity.
  assign result = {exp_field, frac} + {{(EXP_W+FRAC_W-1){1'b0}}, inc};
endmodule

// File: rtl/fp_pack_normalize.sv
// FP32 adder final stage: iterative normalize (one shift/cycle), RNE round, pack.
module fp_pack_normalize
  import fp_pack_normalize_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned GRS_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_pack_normalize_if.slave   bus
);
  localparam int unsigned MANT_W = FRAC_W + GRS_W + 2;
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t                  state, state_nx;
  logic                    sign_r, sign_nx;
  logic [EXP_W:0]          exp_r, exp_nx;
  logic [MANT_W-1:0]       mant_r, mant_nx;
  logic [EXP_W+FRAC_W:0]   out_r, out_nx;

  logic                    carry, hidden, overflow;
  logic [EXP_W-1:0]        exp_field;
  logic [EXP_W+FRAC_W-1:0] rounded;

  assign carry     = mant_r[MANT_W-1];
  assign hidden    = mant_r[MANT_W-2];
  assign overflow  = (exp_r >= EXP_MAX);
  assign exp_field = hidden ? exp_r[EXP_W-1:0] : '0;

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .exp_field (exp_field),
    .frac      (mant_r[MANT_W-3:GRS_W]),
    .guard     (mant_r[2]),
    .round_bit (mant_r[1]),
    .sticky    (mant_r[0]),
    .result    (rounded)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_r;

  always_comb begin
    state_nx = state;
    sign_nx  = sign_r;
    exp_nx   = exp_r;
    mant_nx  = mant_r;
    out_nx   = out_r;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          sign_nx  = bus.in_sign;
          exp_nx   = (bus.in_exp == '0) ? EXP_ONE : bus.in_exp;
          mant_nx  = bus.in_mant;
          state_nx = NORM;
        end
      end
      NORM: begin
        if (mant_r == '0) begin
          out_nx   = {sign_r, {(EXP_W+FRAC_W){1'b0}}};
          state_nx = DONE;
        end else if (carry) begin
          // Right shift folds the dropped bit into sticky (new S = old R | old S).
          mant_nx  = {1'b0, mant_r[MANT_W-1:2], mant_r[1] | mant_r[0]};
          exp_nx   = exp_r + EXP_ONE;
          state_nx = ROUND;
        end else if (!hidden && (exp_r > EXP_ONE)) begin
          mant_nx = mant_r << 1;
          exp_nx  = exp_r - EXP_ONE;
        end else begin
          state_nx = ROUND;
        end
      end
      ROUND: begin
        out_nx   = overflow ? {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                            : {sign_r, rounded};
        state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sign_r <= 1'b0;
      exp_r  <= '0;
      mant_r <= '0;
      out_r  <= '0;
    end else begin
      state  <= state_nx;
      sign_r <= sign_nx;
      exp_r  <= exp_nx;
      mant_r <= mant_nx;
      out_r  <= out_nx;
    end
  end
endmodule
